// File: rtl/mem_arbiter_ram.sv
// Single-port synchronous RAM shared by a data port and an instruction-fetch port,
// with a per-cycle arbiter (fixed data priority or round-robin) and out-of-range flagging.
module mem_arbiter_ram #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              addr_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        WIN_D = 1'b0,
        WIN_I = 1'b1
    } winner_t;

    winner_t           last_winner;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] acc_addr;
    logic [IDX_W-1:0]  acc_idx;
    logic              in_range;
    logic              d_rvalid_q;
    logic              i_rvalid_q;
    logic              err_q;

    // Arbitration: grants are combinational and held off entirely during reset
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!rst) begin
            if (d_req && i_req) begin
                if (ARB_MODE == 0 || last_winner == WIN_I) begin
                    d_gnt = 1'b1;
                end else begin
                    i_gnt = 1'b1;
                end
            end else begin
                d_gnt = d_req;
                i_gnt = i_req;
            end
        end
    end

    assign acc_addr = d_gnt ? d_addr : i_addr;
    assign acc_idx  = IDX_W'(acc_addr);
    assign in_range = (ADDR_W + 1)'(acc_addr) < (ADDR_W + 1)'(DEPTH);

    // RAM array: not reset, out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (d_gnt && d_we && in_range) begin
            mem[acc_idx] <= d_wdata;
        end
    end

    // Synchronous read path, valid strobes and winner history
    always_ff @(posedge clk) begin
        if (rst) begin
            d_rvalid_q  <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rdata     <= '0;
            i_rdata     <= '0;
            err_q       <= 1'b0;
            last_winner <= WIN_I;
        end else begin
            d_rvalid_q <= d_gnt && !d_we;
            i_rvalid_q <= i_gnt;
            err_q      <= (d_gnt || i_gnt) && !in_range;
            if (d_gnt && !d_we) begin
                d_rdata <= in_range ? mem[acc_idx] : '0;
            end
            if (i_gnt) begin
                i_rdata <= in_range ? mem[acc_idx] : '0;
            end
            if (i_gnt) begin
                last_winner <= WIN_I;
            end else if (d_gnt) begin
                last_winner <= WIN_D;
            end
        end
    end

    // A reset arriving in the strobe slot kills a response from a pre-reset grant
    assign d_rvalid = d_rvalid_q && !rst;
    assign i_rvalid = i_rvalid_q && !rst;
    assign addr_err = err_q && !rst;

endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Scoreboard bench for mem_arbiter_ram: one fixed-priority and one round-robin instance,
// both DEPTH=200, driven by directed vectors.
module tb_mem_arbiter_ram;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 200;

    typedef struct {
        int          port;   // 0..3 = dut*2 + (0 data, 1 instr); 4..5 = addr_err of dut 0/1
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_req    [2];
    logic          d_we     [2];
    logic [AW-1:0] d_addr   [2];
    logic [DW-1:0] d_wdata  [2];
    logic          d_gnt    [2];
    logic          d_rvalid [2];
    logic [DW-1:0] d_rdata  [2];
    logic          i_req    [2];
    logic [AW-1:0] i_addr   [2];
    logic          i_gnt    [2];
    logic          i_rvalid [2];
    logic [DW-1:0] i_rdata  [2];
    logic          addr_err [2];

    exp_t          q[$];
    logic [DW-1:0] model [2][256];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]),
        .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]), .addr_err(addr_err[0])
    );

    mem_arbiter_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]),
        .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]), .addr_err(addr_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [DW-1:0] data);
        exp_t e;
        e.port = port;
        e.due  = cyc + 1;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic set_in(input int s, input logic dr, input logic we, input logic [AW-1:0] da,
                          input logic [DW-1:0] wd, input logic ir, input logic [AW-1:0] ia);
        d_req[s] = dr; d_we[s] = we; d_addr[s] = da; d_wdata[s] = wd;
        i_req[s] = ir; i_addr[s] = ia;
    endtask

    // Called at the negedge of a grant cycle: checks grants, queues the expected responses
    task automatic expect_cycle(input int s, input logic eg_d, input logic eg_i, input logic do_push);
        logic oor;
        chk($sformatf("d_gnt[%0d]", s), 32'(d_gnt[s]), 32'(eg_d));
        chk($sformatf("i_gnt[%0d]", s), 32'(i_gnt[s]), 32'(eg_i));
        if (do_push && eg_d) begin
            oor = d_addr[s] >= AW'(DEPTH);
            if (d_we[s]) begin
                if (!oor) model[s][d_addr[s]] = d_wdata[s];
            end else begin
                push(s * 2, oor ? '0 : model[s][d_addr[s]]);
            end
            push(4 + s, DW'(oor));
        end
        if (do_push && eg_i) begin
            oor = i_addr[s] >= AW'(DEPTH);
            push(s * 2 + 1, oor ? '0 : model[s][i_addr[s]]);
            push(4 + s, DW'(oor));
        end
    endtask

    task automatic cyc1(input int s, input logic dr, input logic we, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic ir, input logic [AW-1:0] ia,
                        input logic eg_d, input logic eg_i, input logic do_push);
        set_in(s, dr, we, da, wd, ir, ia);
        set_in(1 - s, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        expect_cycle(s, eg_d, eg_i, do_push);
        @(posedge clk); #1;
    endtask

    // Monitor: matches every strobe and addr_err pulse against the scoreboard
    always @(negedge clk) begin
        logic          v;
        logic [DW-1:0] act;
        int            idx;
        if (!rst) begin
            for (int p = 0; p < 6; p++) begin
                case (p)
                    0: begin v = d_rvalid[0]; act = d_rdata[0]; end
                    1: begin v = i_rvalid[0]; act = i_rdata[0]; end
                    2: begin v = d_rvalid[1]; act = d_rdata[1]; end
                    3: begin v = i_rvalid[1]; act = i_rdata[1]; end
                    4: begin v = 1'b0; act = DW'(addr_err[0]); end
                    default: begin v = 1'b0; act = DW'(addr_err[1]); end
                endcase
                idx = -1;
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].port == p) begin
                        idx = i;
                        break;
                    end
                end
                if (p < 4) begin
                    if (v) begin
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL rvalid port %0d @cyc %0d: unexpected strobe, data %h", p, cyc, act);
                        end else begin
                            if (q[idx].due != cyc || act !== q[idx].data) begin
                                errors++;
                                $display("FAIL rdata port %0d @cyc %0d: got %h expected %h due cyc %0d",
                                         p, cyc, act, q[idx].data, q[idx].due);
                            end
                            q.delete(idx);
                        end
                    end else if (idx >= 0 && q[idx].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL rvalid port %0d @cyc %0d: got 0 expected 1 (data %h)", p, cyc, q[idx].data);
                        q.delete(idx);
                    end
                end else begin
                    if (idx >= 0 && q[idx].due == cyc) begin
                        checks++;
                        if (act[0] !== q[idx].data[0]) begin
                            errors++;
                            $display("FAIL addr_err[%0d] @cyc %0d: got %b expected %b", p - 4, cyc, act[0], q[idx].data[0]);
                        end
                        q.delete(idx);
                    end else if (act[0] !== 1'b0) begin
                        checks++;
                        errors++;
                        $display("FAIL addr_err[%0d] @cyc %0d: got %b expected 0", p - 4, cyc, act[0]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with both requests high on both instances
        set_in(0, 1'b1, 1'b0, 8'd1, '0, 1'b1, 8'd2);
        set_in(1, 1'b1, 1'b0, 8'd1, '0, 1'b1, 8'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk("rst d_gnt", 32'(d_gnt[s]), 32'd0);
                chk("rst i_gnt", 32'(i_gnt[s]), 32'd0);
                chk("rst d_rvalid", 32'(d_rvalid[s]), 32'd0);
                chk("rst i_rvalid", 32'(i_rvalid[s]), 32'd0);
                chk("rst d_rdata", 32'(d_rdata[s]), 32'd0);
                chk("rst i_rdata", 32'(i_rdata[s]), 32'd0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // First cycle after reset: data wins on both instances
        set_in(0, 1'b1, 1'b1, 8'd1, 16'h0101, 1'b1, 8'd2);
        set_in(1, 1'b1, 1'b1, 8'd1, 16'h0101, 1'b1, 8'd2);
        @(negedge clk);
        expect_cycle(0, 1'b1, 1'b0, 1'b1);
        expect_cycle(1, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Preload both memories
        for (int s = 0; s < 2; s++) begin
            cyc1(s, 1'b1, 1'b1, 8'd2,   16'h0202, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            cyc1(s, 1'b1, 1'b1, 8'd5,   16'h0505, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            cyc1(s, 1'b1, 1'b1, 8'd20,  16'h2020, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            cyc1(s, 1'b1, 1'b1, 8'd199, 16'h0C7C, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        end

        // Write then immediate read-back
        cyc1(0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc1(0, 1'b1, 1'b0, 8'h10, '0,       1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Fixed priority: data wins every cycle, instruction gets in once data drops
        for (int k = 0; k < 4; k++)
            cyc1(0, 1'b1, 1'b0, 8'd1, '0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
        cyc1(0, 1'b0, 1'b0, 8'd1, '0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1);
        cyc1(0, 1'b0, 1'b0, '0,   '0, 1'b0, '0,   1'b0, 1'b0, 1'b1);

        // Range boundary: 220 and 200 flagged, 199 valid, out-of-range write does not alias onto 20
        cyc1(0, 1'b1, 1'b0, 8'd220, '0,       1'b0, '0,     1'b1, 1'b0, 1'b1);
        cyc1(0, 1'b1, 1'b1, 8'd220, 16'h1234, 1'b0, '0,     1'b1, 1'b0, 1'b1);
        cyc1(0, 1'b1, 1'b0, 8'd20,  '0,       1'b0, '0,     1'b1, 1'b0, 1'b1);
        cyc1(0, 1'b0, 1'b0, '0,     '0,       1'b1, 8'd199, 1'b0, 1'b1, 1'b1);
        cyc1(0, 1'b0, 1'b0, '0,     '0,       1'b1, 8'd200, 1'b0, 1'b1, 1'b1);
        cyc1(0, 1'b0, 1'b0, '0,     '0,       1'b0, '0,     1'b0, 1'b0, 1'b1);

        // Round-robin: a lone fetch leaves instruction as last winner, then D,I,D,I,D,I
        cyc1(1, 1'b0, 1'b0, '0, '0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++)
            cyc1(1, 1'b1, 1'b0, 8'd1, '0, 1'b1, 8'd2, (k % 2) == 0, (k % 2) == 1, 1'b1);
        cyc1(1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Reset in the strobe slot of a granted fetch
        cyc1(0, 1'b0, 1'b0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        set_in(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid i_rvalid", 32'(i_rvalid[0]), 32'd0);
        chk("rst-mid addr_err", 32'(addr_err[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst-mid i_rvalid2", 32'(i_rvalid[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-rst i_rdata", 32'(i_rdata[0]), 32'd0);
        cyc1(0, 1'b0, 1'b0, '0, '0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b1);
        cyc1(0, 1'b0, 1'b0, '0, '0, 1'b0, '0,   1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
